// File: rtl/adder_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// adder_arbiter_pkg
// Shared definitions for the adder arbiter:
//   state_e    - FSM state encoding (IDLE, EXEC, RESP)
//   DEF_NREQ   - default number of requesters sharing the adder
//   DEF_WIDTH  - default operand / sum width
// ---------------------------------------------------------------------------
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Stateless round-robin selector. Picks the first set request bit searching
// upward from (last_grant_i + 1) modulo NREQ and returns it one-hot.
// Ports:
//   req_i        in  NREQ  request vector
//   last_grant_i in  IDW   index of the most recently granted requester
//   grant_o      out NREQ  one-hot grant (all zero when req_i is zero)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic [NREQ-1:0] grant_o
);

    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] pick_from;

    // Requests strictly above last_grant take priority; if there are none the
    // search wraps around to the lowest set bit of the full request vector.
    always_comb begin
        upper = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper[i] = req_i[i] && (i > int'(last_grant_i));
        end
        pick_from = (|upper) ? upper : req_i;
    end

    // Scan downward so the lowest set bit is the one left standing.
    always_comb begin
        grant_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick_from[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
// NREQ requesters share one registered (WIDTH+1)-bit adder. A round-robin
// arbiter picks one requester in IDLE; its operands are captured, summed in
// EXEC and presented in RESP until the consumer accepts the result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is one-hot and only asserted in IDLE; rsp_valid is
// high exactly in RESP and the response fields are held until rsp_ready.
// A request seen in cycle N is presented as a response from cycle N+2.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid [NREQ] per-requester valid
//   req_a, req_b     per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready [NREQ] one-hot acceptance
//   rsp_valid/ready  response handshake
//   rsp_id           index of the requester owning the result
//   rsp_sum          sum modulo 2^WIDTH
//   rsp_carry        carry-out of the sum
//   busy             high whenever the FSM is not IDLE
//   dbg_state        current FSM state (state_e encoding)
// ---------------------------------------------------------------------------
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    state_e           state_q;
    logic [IDW-1:0]   last_grant_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH:0]   res_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             accept;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Gated by rst so nothing is offered while reset is held.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // One-hot grant to index and operand mux.
    always_comb begin
        grant_id = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_id = IDW'(i);
                sel_a    = req_a[i*WIDTH +: WIDTH];
                sel_b    = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            // Start at NREQ-1 so requester 0 is first in line.
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q       <= sel_a;
                        op_b_q       <= sel_b;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= {1'b0, op_a_q} + {1'b0, op_b_q};
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_sum   = res_q[WIDTH-1:0];
    assign rsp_carry = res_q[WIDTH];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter
// Directed scenarios followed by random traffic. The driver task applies one
// cycle of stimulus, checks req_ready/busy against a round-robin model and
// pushes the expected response; a separate monitor pops and compares
// whenever the DUT presents rsp_valid.
// ---------------------------------------------------------------------------
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int EW    = IDW + 1 + WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic                  busy;
    logic [1:0]            dbg_state;

    adder_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            dut_grant_log[$];
    int            dut_grant_cyc[$];
    bit            model_busy = 1'b0;
    int            model_last = NREQ - 1;

    logic [NREQ*WIDTH-1:0] va;
    logic [NREQ*WIDTH-1:0] vb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first valid requester after the last grant.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (((v >> idx) & NREQ'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*WIDTH-1:0] rand_ops();
        logic [NREQ*WIDTH-1:0] r;
        for (int i = 0; i < NREQ; i++) begin
            r[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] a,
                               input logic [NREQ*WIDTH-1:0] b, input logic rr);
        logic [NREQ-1:0] exp_rdy;
        int              g;
        int              s;
        @(posedge clk);
        #1;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        @(negedge clk);
        exp_rdy = '0;
        g       = -1;
        if (!model_busy) begin
            g = rr_pick(v, model_last);
            if (g >= 0) exp_rdy = NREQ'(1) << g;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(model_busy));
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && v[i]) begin
                dut_grant_log.push_back(i);
                dut_grant_cyc.push_back(cyc);
            end
        end
        if (g >= 0) begin
            s = int'(a[g*WIDTH +: WIDTH]) + int'(b[g*WIDTH +: WIDTH]);
            exp_q.push_back({IDW'(g), s[WIDTH], s[WIDTH-1:0]});
            exp_cyc_q.push_back(cyc + 2);
            model_last = g;
            model_busy = 1'b1;
        end
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) drive_cycle('0, rand_ops(), rand_ops(), rr);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit presented;
        presented = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                presented = 1'b0;
            end else if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h carry=%0d, expected no response (cycle %0d)",
                             rsp_id, rsp_sum, rsp_carry, cyc);
                end else begin
                    check("rsp_fields", 32'({rsp_id, rsp_carry, rsp_sum}), 32'(exp_q[0]));
                    if (!presented) check("rsp_latency", 32'(cyc), 32'(exp_cyc_q[0]));
                    presented = 1'b1;
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                        presented = 1'b0;
                        @(posedge clk);
                        model_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst       = 1'b0;

        // Single request from requester 2: 0x30 + 0x12; operands change afterwards.
        va = rand_ops(); vb = rand_ops();
        va[2*WIDTH +: WIDTH] = 8'h30;
        vb[2*WIDTH +: WIDTH] = 8'h12;
        drive_cycle(4'b0100, va, vb, 1'b1);
        idle(3, 1'b1);

        // Carry-out case.
        va = '1;
        vb = {NREQ{8'h02}};
        drive_cycle(4'b0001, va, vb, 1'b1);
        idle(3, 1'b1);

        // Put last grant on requester 3, then hold all four valid.
        drive_cycle(4'b1000, rand_ops(), rand_ops(), 1'b1);
        idle(3, 1'b1);
        dut_grant_log.delete();
        dut_grant_cyc.delete();
        repeat (13) drive_cycle(4'b1111, rand_ops(), rand_ops(), 1'b1);
        check("rr_grant_count", 32'(dut_grant_log.size()), 32'd5);
        for (int i = 0; i < dut_grant_log.size() && i < 5; i++) begin
            check("rr_grant_order", 32'(dut_grant_log[i]), 32'(i % NREQ));
            if (i > 0) check("rr_grant_spacing", 32'(dut_grant_cyc[i] - dut_grant_cyc[i-1]), 32'd3);
        end
        idle(3, 1'b1);

        // Consumer stall: five RESP cycles with rsp_ready low, others requesting.
        drive_cycle(4'b0010, rand_ops(), rand_ops(), 1'b0);
        repeat (6) drive_cycle(4'b1111, rand_ops(), rand_ops(), 1'b0);
        drive_cycle(4'b1111, rand_ops(), rand_ops(), 1'b1);
        drive_cycle(4'b1111, rand_ops(), rand_ops(), 1'b1);
        idle(3, 1'b1);

        // Wrap-around: last grant 1, requesters 0 and 1 valid -> 0.
        drive_cycle(4'b0010, rand_ops(), rand_ops(), 1'b1);
        idle(3, 1'b1);
        dut_grant_log.delete();
        drive_cycle(4'b0011, rand_ops(), rand_ops(), 1'b1);
        check("wrap_grant_seen", 32'(dut_grant_log.size()), 32'd1);
        if (dut_grant_log.size() > 0) check("wrap_grant_id", 32'(dut_grant_log[0]), 32'd0);
        idle(3, 1'b1);

        // Reset pulse during EXEC.
        drive_cycle(4'b0100, rand_ops(), rand_ops(), 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_id", 32'(rsp_id), 32'd0);
        check("midrst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("midrst_rsp_carry", 32'(rsp_carry), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        model_busy = 1'b0;
        model_last = NREQ - 1;
        @(negedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;
        idle(4, 1'b1);
        dut_grant_log.delete();
        drive_cycle(4'b1111, rand_ops(), rand_ops(), 1'b1);
        check("post_rst_grant_seen", 32'(dut_grant_log.size()), 32'd1);
        if (dut_grant_log.size() > 0) check("post_rst_grant_id", 32'(dut_grant_log[0]), 32'd0);
        idle(3, 1'b1);

        // Random traffic.
        repeat (400) begin
            logic [NREQ-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, (1 << NREQ) - 1));
            drive_cycle(v, rand_ops(), rand_ops(), $urandom_range(0, 3) != 0);
        end

        // Drain outstanding responses within a fixed budget.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1, 1'b1);
        idle(1, 1'b1);
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001: Parameter NREQ, default 4, SHALL set the number of requesters sharing the adder (2..8).
REQ-002: Parameter WIDTH, default 8, SHALL set the operand and sum width.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005: req_valid  input  NREQ  SHALL carry the per-requester request-valid bits.
REQ-006: req_a, req_b  input  NREQ*WIDTH each  SHALL carry the per-requester operands, with requester i in bits [i*WIDTH +: WIDTH].
REQ-007: req_ready  output  NREQ  SHALL be the one-hot acceptance signal, combinational from state, pointer and req_valid.
REQ-008: rsp_valid  output  1  SHALL indicate that a result is presented.
REQ-009: rsp_ready  input  1  SHALL indicate that the consumer accepts the presented result.
REQ-010: rsp_id  output  clog2(NREQ)  SHALL give the index of the requester that owns the result.
REQ-011: rsp_sum  output  WIDTH  SHALL give the modulo-2^WIDTH sum of the captured operands.
REQ-012: rsp_carry  output  1  SHALL give the carry-out of the sum.
REQ-013: busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-014: The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-015: In IDLE with any req_valid bit set, exactly one req_ready bit SHALL be high: the first set bit searching upward from (last_grant+1) mod NREQ.
REQ-016: A handshake (req_valid[i] & req_ready[i]) SHALL capture req_a[i], req_b[i] and i into operand registers, set last_grant to i, and move IDLE->EXEC.
REQ-017: In IDLE with no req_valid bit set, req_ready SHALL be all zero, the FSM SHALL stay in IDLE, and last_grant SHALL hold.
REQ-018: req_ready SHALL be all zero in EXEC and RESP.
REQ-019: EXEC SHALL register the (WIDTH+1)-bit sum of the operand registers into the result register and move unconditionally to RESP.
REQ-020: In RESP, rsp_valid SHALL be high and rsp_id, rsp_sum and rsp_carry SHALL be stable until the handshake.
REQ-021: A RESP handshake (rsp_valid & rsp_ready) SHALL move RESP->IDLE; with rsp_ready low the FSM SHALL remain in RESP.
REQ-022: Latency SHALL be fixed: a request accepted at edge N produces rsp_valid high from edge N+2.
REQ-023: Minimum spacing between accepted requests SHALL be 3 cycles.
REQ-024: A requester that drops req_valid before being granted SHALL be skipped, with no error and no state change.
REQ-025: Operand inputs SHALL be ignored outside the accepting IDLE cycle; changes during EXEC or RESP SHALL not affect the result.
REQ-026: Round-robin SHALL guarantee that a continuously-valid requester is granted within NREQ grants.

Reset
REQ-027: Asserting rst SHALL immediately force IDLE, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0 and req_ready=0, and set last_grant=NREQ-1 so that requester 0 has first priority.
REQ-028: Reset asserted mid-operation (EXEC or RESP) SHALL discard the in-flight result; no rsp_valid SHALL follow the release of reset.
REQ-029: The first acceptance SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-030: A shared package SHALL hold the state enum (IDLE, EXEC, RESP) and the default NREQ and WIDTH constants.
REQ-031: Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last_grant; output: one-hot grant), with no internal state.
REQ-032: The adder SHALL be a single registered WIDTH+1 adder shared by all requesters.

Verification
REQ-033: Release reset; req_valid[2]=1 with a=8'h30, b=8'h12 -> req_ready=4'b0100 the same cycle; two edges later rsp_valid=1, rsp_id=2, rsp_sum=8'h42, rsp_carry=0.
REQ-034: a=8'hFF, b=8'h02 -> rsp_sum=8'h01, rsp_carry=1.
REQ-035: All four requesters held valid, rsp_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles.
REQ-036: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp outputs stable and req_ready=0 throughout; raising rsp_ready returns the FSM to IDLE on the next edge.
REQ-037: rst pulsed during EXEC -> all outputs 0 asynchronously, no response afterwards, and the next grant goes to requester 0.
REQ-038: last_grant=1 with req_valid=4'b0011 -> grant goes to requester 0 (wrap-around), skipping the invalid requesters 2 and 3.
